axi4_stream_rr_arbiter: RTL and testbench

//  Shares one AXI4-Stream sink (the axi4_stream_fifo write side, clk_i domain) between NB_OF_INPUTS

---
 rtl/axi4_stream_pkg.sv | 38 +++
 rtl/axi4_stream_rr_picker.sv | 30 +++
 rtl/axi4_stream_rr_arbiter.sv | 114 +++++++++++
 tb/tb_axi4_stream_rr_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_stream_pkg.sv
// Shared types and the round-robin search helper for the AXI4-Stream arbiter.
//   arb_state_t : arbiter FSM state (idle/arbitrating vs. locked on a grant)
//   rr_pick_t   : result of a round-robin search (found flag + winning index)
//   rr_pick()   : first set request starting at ptr, wrapping modulo nb
package axi4_stream_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_t;

    localparam int unsigned RR_MAX_REQ = 32;
    localparam int unsigned RR_IDX_W   = 5;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // Search ptr..nb-1 then 0..ptr-1; ptr must be below nb.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX_REQ-1:0] req,
                                         input logic [RR_IDX_W-1:0]   ptr,
                                         input int unsigned           nb);
        rr_pick_t    res;
        int unsigned j;
        res = '0;
        for (int unsigned k = 0; k < RR_MAX_REQ; k++) begin
            j = 32'(ptr) + k;
            if (j >= nb) j = j - nb;
            if (k < nb && !res.found && req[j[RR_IDX_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = j[RR_IDX_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axi4_stream_rr_picker.sv
// Combinational round-robin picker.
//   req     : per-requester request vector
//   ptr     : index where the search starts
//   found_c : at least one request is set
//   idx_c   : winning requester index
module axi4_stream_rr_picker
    import axi4_stream_pkg::*;
#(
    parameter  int unsigned NB_OF_INPUTS = 4,
    localparam int unsigned IDX_W        = (NB_OF_INPUTS > 1) ? $clog2(NB_OF_INPUTS) : 1
) (
    input  logic [NB_OF_INPUTS-1:0] req,
    input  logic [IDX_W-1:0]        ptr,
    output logic                    found_c,
    output logic [IDX_W-1:0]        idx_c
);

    rr_pick_t pick;

    // Decode the package-width index back to the local width.
    always_comb begin
        pick    = rr_pick(RR_MAX_REQ'(req), RR_IDX_W'(ptr), NB_OF_INPUTS);
        found_c = pick.found;
        idx_c   = '0;
        for (int unsigned i = 0; i < NB_OF_INPUTS; i++) begin
            if (pick.idx == RR_IDX_W'(i)) idx_c = IDX_W'(i);
        end
    end

endmodule

// File: rtl/axi4_stream_rr_arbiter.sv
// Round-robin arbiter sharing one AXI4-Stream sink between NB_OF_INPUTS
// requesters. A grant is held for up to MAX_BURST beats (or until the
// granted requester drops tvalid), then a one-cycle arbitration bubble
// picks the next requester starting after the previous one.
//   clk_i, rst_ni    : clock, synchronous active-low reset
//   data_in_*        : requester i on tdata[i*DATA_SIZE +: DATA_SIZE], tvalid[i], tready[i]
//   data_out_*       : registered output beat, tid = source index
module axi4_stream_rr_arbiter
    import axi4_stream_pkg::*;
#(
    parameter  int unsigned DATA_SIZE    = 8,
    parameter  int unsigned NB_OF_INPUTS = 4,
    parameter  int unsigned MAX_BURST    = 4,
    localparam int unsigned TID_W        = (NB_OF_INPUTS > 1) ? $clog2(NB_OF_INPUTS) : 1
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NB_OF_INPUTS*DATA_SIZE-1:0] data_in_tdata,
    input  logic [NB_OF_INPUTS-1:0]           data_in_tvalid,
    output logic [NB_OF_INPUTS-1:0]           data_in_tready,
    output logic [DATA_SIZE-1:0]              data_out_tdata,
    output logic [TID_W-1:0]                  data_out_tid,
    output logic                              data_out_tvalid,
    input  logic                              data_out_tready
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t           state;
    logic [TID_W-1:0]     rr_ptr;
    logic [TID_W-1:0]     grant;
    logic [CNT_W-1:0]     beat_cnt;

    logic                 pick_found;
    logic [TID_W-1:0]     pick_idx;
    logic                 can_load;
    logic                 grant_valid;
    logic [DATA_SIZE-1:0] sel_data;
    logic                 accept;
    logic                 last_beat;
    logic [TID_W-1:0]     next_ptr;

    axi4_stream_rr_picker #(
        .NB_OF_INPUTS (NB_OF_INPUTS)
    ) u_picker (
        .req     (data_in_tvalid),
        .ptr     (rr_ptr),
        .found_c (pick_found),
        .idx_c   (pick_idx)
    );

    // Output register can take a beat when empty or draining this cycle.
    assign can_load = !data_out_tvalid || data_out_tready;

    // Granted-requester mux and one-hot ready.
    always_comb begin
        sel_data       = '0;
        grant_valid    = 1'b0;
        data_in_tready = '0;
        for (int unsigned i = 0; i < NB_OF_INPUTS; i++) begin
            if (grant == TID_W'(i)) begin
                sel_data          = data_in_tdata[i*DATA_SIZE +: DATA_SIZE];
                grant_valid       = data_in_tvalid[i];
                data_in_tready[i] = rst_ni && (state == ARB_LOCKED) && can_load;
            end
        end
    end

    assign accept    = (state == ARB_LOCKED) && grant_valid && can_load;
    assign last_beat = (beat_cnt == CNT_W'(MAX_BURST - 1));
    assign next_ptr  = (grant == TID_W'(NB_OF_INPUTS - 1)) ? '0 : grant + TID_W'(1);

    // Arbitration FSM, burst counter and output register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state           <= ARB_IDLE;
            rr_ptr          <= '0;
            grant           <= '0;
            beat_cnt        <= '0;
            data_out_tvalid <= 1'b0;
            data_out_tdata  <= '0;
            data_out_tid    <= '0;
        end else begin
            if (accept) begin
                data_out_tvalid <= 1'b1;
                data_out_tdata  <= sel_data;
                data_out_tid    <= grant;
            end else if (data_out_tready) begin
                data_out_tvalid <= 1'b0;
            end

            case (state)
                ARB_IDLE: begin
                    if (pick_found) begin
                        grant    <= pick_idx;
                        beat_cnt <= '0;
                        state    <= ARB_LOCKED;
                    end
                end
                ARB_LOCKED: begin
                    // Release on a full burst or when the owner has drained.
                    if ((accept && last_beat) || !grant_valid) begin
                        state  <= ARB_IDLE;
                        rr_ptr <= next_ptr;
                    end else if (accept) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_stream_rr_arbiter.sv
module tb_axi4_stream_rr_arbiter;

    localparam int unsigned NB = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned TW = 2;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [NB*DW-1:0] in_data;
    logic [NB-1:0] in_valid;
    logic [NB-1:0] in_ready;
    logic [DW-1:0] out_data;
    logic [TW-1:0] out_tid;
    logic          out_valid;
    logic          out_ready;

    always #5 clk_i = ~clk_i;

    axi4_stream_rr_arbiter #(
        .DATA_SIZE    (DW),
        .NB_OF_INPUTS (NB),
        .MAX_BURST    (4)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .data_in_tdata   (in_data),
        .data_in_tvalid  (in_valid),
        .data_in_tready  (in_ready),
        .data_out_tdata  (out_data),
        .data_out_tid    (out_tid),
        .data_out_tvalid (out_valid),
        .data_out_tready (out_ready)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: wait bound expired, required completion", nm);
    endtask

    // Reference state: per-source pending beats and expected output order.
    logic [DW-1:0] src_q [NB][$];
    logic [DW-1:0] exp_q [NB][$];
    logic [NB-1:0] vld_r;
    bit            auto_drv = 1'b0;
    bit            auto_rdy = 1'b0;
    bit            mon_en   = 1'b0;
    int unsigned   vld_pct  = 100;
    int unsigned   rdy_pct  = 100;
    int            n_out;
    int            acc_cnt [NB];
    int            wait_cnt [NB];
    int            last_src;
    int            cyc_log [$];
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic [TW-1:0] prev_tid;

    // AXI source driver: valid stays up until its handshake.
    always @(negedge clk_i) begin
        if (auto_drv) begin
            for (int i = 0; i < NB; i++) begin
                if (!vld_r[i] && src_q[i].size() > 0 && $urandom_range(99) < vld_pct)
                    vld_r[i] = 1'b1;
                if (vld_r[i]) in_data[i*DW +: DW] = src_q[i][0];
            end
            in_valid = vld_r;
            if (auto_rdy) out_ready = ($urandom_range(99) < rdy_pct);
        end
    end

    // Monitor, sampled just before the rising edge.
    always @(negedge clk_i) begin : mon
        int   code;
        logic ld;
        #4;
        if (rst_ni && mon_en) begin
            check("ready_onehot0", 32'($onehot0(in_ready)), 1);
            if (prev_stall) begin
                check("hold_valid", 32'(out_valid), 1);
                check("hold_data", 32'(out_data), 32'(prev_data));
                check("hold_tid", 32'(out_tid), 32'(prev_tid));
            end
            if (out_valid && out_ready) begin
                if (exp_q[out_tid].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out_unexpected: got tid %0d data 0x%0h, required no beat", out_tid, out_data);
                end else begin
                    check($sformatf("out_data_tid%0d", out_tid), 32'(out_data), 32'(exp_q[out_tid].pop_front()));
                end
                n_out++;
            end
            code = -1;
            for (int i = 0; i < NB; i++) begin
                if (in_valid[i] && in_ready[i]) begin
                    code = i;
                    void'(src_q[i].pop_front());
                    vld_r[i] = 1'b0;
                    acc_cnt[i]++;
                end
            end
            // A waiting source may see at most NB-1 other grants.
            if (code >= 0) begin
                for (int i = 0; i < NB; i++) begin
                    if (i == code) begin
                        wait_cnt[i] = 0;
                    end else if (in_valid[i] && code != last_src) begin
                        wait_cnt[i]++;
                        check($sformatf("starvation_src%0d", i), 32'(wait_cnt[i] <= NB - 1), 1);
                    end
                end
                last_src = code;
            end
            for (int i = 0; i < NB; i++) if (!in_valid[i]) wait_cnt[i] = 0;
            ld = !out_valid || out_ready;
            if (code < 0 && in_ready == '0 && ld) code = -2;
            cyc_log.push_back(code);
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_tid   = out_tid;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic clear_model();
        for (int i = 0; i < NB; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
            acc_cnt[i]  = 0;
            wait_cnt[i] = 0;
        end
        vld_r      = '0;
        in_valid   = '0;
        cyc_log.delete();
        n_out      = 0;
        last_src   = -1;
        prev_stall = 1'b0;
    endtask

    task automatic tb_reset();
        auto_drv  = 1'b0;
        mon_en    = 1'b0;
        auto_rdy  = 1'b0;
        rst_ni    = 1'b0;
        out_ready = 1'b1;
        clear_model();
        repeat (2) @(negedge clk_i);
        rst_ni   = 1'b1;
        vld_pct  = 100;
        mon_en   = 1'b1;
        auto_drv = 1'b1;
    endtask

    task automatic push_beat(input int s, input logic [DW-1:0] d);
        src_q[s].push_back(d);
        exp_q[s].push_back(d);
    endtask

    task automatic wait_idle(input string nm, input int budget);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk_i);
            if (src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size() == 0
                && vld_r == '0 && !out_valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) fail_now(nm);
        repeat (3) @(negedge clk_i);
    endtask

    task automatic wait_acc(input string nm, input int s, input int n, input int budget);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk_i);
            if (acc_cnt[s] >= n) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) fail_now(nm);
    endtask

    // Grant runs: accepts grouped between arbitration bubbles.
    int exp_src [8];
    int exp_len [8];
    int n_exp;

    task automatic check_runs(input string nm);
        int rs [$];
        int rl [$];
        int cur;
        int len;
        cur = -1;
        len = 0;
        foreach (cyc_log[k]) begin
            if (cyc_log[k] == -2) begin
                if (len > 0) begin rs.push_back(cur); rl.push_back(len); end
                len = 0;
            end else if (cyc_log[k] >= 0) begin
                if (len > 0 && cyc_log[k] != cur) begin
                    rs.push_back(cur);
                    rl.push_back(len);
                    len = 0;
                end
                cur = cyc_log[k];
                len++;
            end
        end
        if (len > 0) begin rs.push_back(cur); rl.push_back(len); end
        check($sformatf("%s_nruns", nm), rs.size(), n_exp);
        for (int k = 0; k < n_exp; k++) begin
            if (k < rs.size()) begin
                check($sformatf("%s_run%0d_src", nm, k), rs[k], exp_src[k]);
                check($sformatf("%s_run%0d_len", nm, k), rl[k], exp_len[k]);
            end
        end
    endtask

    typedef struct {
        logic [3:0] vld;
        logic [7:0] d2;
        logic       rdy;
        logic [3:0] trdy;
        logic       ov;
        logic [7:0] od;
        logic [1:0] tid;
    } vec_t;

    vec_t tbl [10];

    initial begin
        // Single source on in[2]: 4-beat burst, bubble, 2-beat burst, drain release.
        tbl[0] = '{4'b0100, 8'h10, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};
        tbl[1] = '{4'b0100, 8'h10, 1'b1, 4'b0100, 1'b0, 8'h00, 2'd0};
        tbl[2] = '{4'b0100, 8'h11, 1'b1, 4'b0100, 1'b1, 8'h10, 2'd2};
        tbl[3] = '{4'b0100, 8'h12, 1'b1, 4'b0100, 1'b1, 8'h11, 2'd2};
        tbl[4] = '{4'b0100, 8'h13, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
        tbl[5] = '{4'b0100, 8'h14, 1'b1, 4'b0000, 1'b1, 8'h13, 2'd2};
        tbl[6] = '{4'b0100, 8'h14, 1'b1, 4'b0100, 1'b0, 8'h00, 2'd0};
        tbl[7] = '{4'b0100, 8'h15, 1'b1, 4'b0100, 1'b1, 8'h14, 2'd2};
        tbl[8] = '{4'b0000, 8'h00, 1'b1, 4'b0100, 1'b1, 8'h15, 2'd2};
        tbl[9] = '{4'b0000, 8'h00, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};

        // Reset with every requester valid.
        clear_model();
        rst_ni    = 1'b0;
        in_valid  = '1;
        in_data   = {$urandom, $urandom} ;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            #1;
            check("reset_tready", 32'(in_ready), 0);
            check("reset_tvalid", 32'(out_valid), 0);
            check("reset_tid", 32'(out_tid), 0);
            check("reset_tdata", 32'(out_data), 0);
        end
        @(negedge clk_i);
        in_valid = '0;
        rst_ni   = 1'b1;

        // Table-driven single-source sequence.
        foreach (tbl[r]) begin
            @(negedge clk_i);
            in_valid          = tbl[r].vld;
            in_data[2*DW +: DW] = tbl[r].d2;
            out_ready         = tbl[r].rdy;
            #1;
            check($sformatf("tbl%0d_tready", r), 32'(in_ready), 32'(tbl[r].trdy));
            check($sformatf("tbl%0d_tvalid", r), 32'(out_valid), 32'(tbl[r].ov));
            if (tbl[r].ov) begin
                check($sformatf("tbl%0d_tdata", r), 32'(out_data), 32'(tbl[r].od));
                check($sformatf("tbl%0d_tid", r), 32'(out_tid), 32'(tbl[r].tid));
            end
        end

        // All four busy: bursts of four in strict rotation.
        tb_reset();
        for (int s = 0; s < NB; s++)
            for (int b = 0; b < 8; b++) push_beat(s, 8'(s * 16 + b));
        wait_idle("all_busy_drain", 300);
        n_exp = 8;
        for (int k = 0; k < 8; k++) begin
            exp_src[k] = k % NB;
            exp_len[k] = 4;
        end
        check_runs("all_busy");
        check("all_busy_count", n_out, 32);

        // Backpressure mid-burst from in[1].
        tb_reset();
        for (int b = 0; b < 6; b++) push_beat(1, 8'(8'h20 + b));
        wait_acc("bp_first_accept", 1, 1, 20);
        out_ready = 1'b0;
        #1;
        check("bp_stall0_tready", 32'(in_ready), 0);
        check("bp_stall0_tvalid", 32'(out_valid), 1);
        @(negedge clk_i);
        #1;
        check("bp_stall1_tready", 32'(in_ready), 0);
        check("bp_stall1_tdata", 32'(out_data), 32'h20);
        check("bp_stall1_tid", 32'(out_tid), 1);
        @(negedge clk_i);
        out_ready = 1'b1;
        wait_idle("bp_drain", 100);
        n_exp = 2;
        exp_src[0] = 1; exp_len[0] = 4;
        exp_src[1] = 1; exp_len[1] = 2;
        check_runs("bp");
        check("bp_count", n_out, 6);

        // Early release of in[0], pointer wrap after in[3].
        tb_reset();
        push_beat(0, 8'hA0);
        push_beat(0, 8'hA1);
        for (int b = 0; b < 3; b++) push_beat(3, 8'(8'hD0 + b));
        wait_idle("early_drain", 100);
        push_beat(1, 8'hB0);
        push_beat(0, 8'hA2);
        wait_idle("wrap_drain", 100);
        n_exp = 4;
        exp_src[0] = 0; exp_len[0] = 2;
        exp_src[1] = 3; exp_len[1] = 3;
        exp_src[2] = 0; exp_len[2] = 1;
        exp_src[3] = 1; exp_len[3] = 1;
        check_runs("early");

        // Reset in the middle of a burst from in[1].
        tb_reset();
        push_beat(2, 8'h60);
        wait_idle("midrst_pre", 50);
        for (int b = 0; b < 4; b++) push_beat(1, 8'(8'h70 + b));
        wait_acc("midrst_two_beats", 1, 2, 30);
        rst_ni   = 1'b0;
        mon_en   = 1'b0;
        auto_drv = 1'b0;
        clear_model();
        @(negedge clk_i);
        #1;
        check("midrst_tvalid", 32'(out_valid), 0);
        check("midrst_tready", 32'(in_ready), 0);
        check("midrst_tid", 32'(out_tid), 0);
        rst_ni   = 1'b1;
        mon_en   = 1'b1;
        auto_drv = 1'b1;
        push_beat(3, 8'h83);
        push_beat(0, 8'h80);
        wait_idle("midrst_post", 50);
        n_exp = 2;
        exp_src[0] = 0; exp_len[0] = 1;
        exp_src[1] = 3; exp_len[1] = 1;
        check_runs("midrst");

        // Random traffic with random valid gaps and backpressure.
        tb_reset();
        vld_pct  = 60;
        rdy_pct  = 70;
        auto_rdy = 1'b1;
        for (int k = 0; k < 4096; k++) push_beat(int'($urandom_range(NB - 1)), 8'($urandom));
        for (int c = 0; c < 40000 && n_out < 4096; c++) @(negedge clk_i);
        check("rand_count", n_out, 4096);
        for (int s = 0; s < NB; s++) check($sformatf("rand_left_src%0d", s), exp_q[s].size(), 0);
        auto_rdy  = 1'b0;
        out_ready = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
